// File: rtl/lcd_ctrl_if.sv
// LSU-side register word and HD44780 pin bundle for lcd_ctrl.
// master: the LSU/status side; slave: the sequencer driving the pins.
interface lcd_ctrl_if;
  logic [31:0] io_lcd;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        busy;

  modport master (
    output io_lcd,
    input  lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, busy
  );

  modport slave (
    input  io_lcd,
    output lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, busy
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up init, then timed E/RS/DATA transfers launched by START
// edges in the io_lcd word, with a 1-deep last-wins pending buffer.
module lcd_ctrl #(
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_PULSE   = 25,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_EXEC    = 2500,
  parameter int unsigned T_CLEAR   = 100000,
  parameter int unsigned T_POWERUP = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  lcd_ctrl_if.slave lcd_bus_io
);

  // A zero delay would never match a 0..T-1 count, so clamp to one cycle.
  localparam int unsigned SetupCyc   = (T_SETUP   == 0) ? 1 : T_SETUP;
  localparam int unsigned PulseCyc   = (T_PULSE   == 0) ? 1 : T_PULSE;
  localparam int unsigned HoldCyc    = (T_HOLD    == 0) ? 1 : T_HOLD;
  localparam int unsigned ExecCyc    = (T_EXEC    == 0) ? 1 : T_EXEC;
  localparam int unsigned ClearCyc   = (T_CLEAR   == 0) ? 1 : T_CLEAR;
  localparam int unsigned PowerupCyc = (T_POWERUP == 0) ? 1 : T_POWERUP;

  localparam logic [CNT_W-1:0] SetupLast   = CNT_W'(SetupCyc - 1);
  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PulseCyc - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HoldCyc - 1);
  localparam logic [CNT_W-1:0] ExecLast    = CNT_W'(ExecCyc - 1);
  localparam logic [CNT_W-1:0] ClearLast   = CNT_W'(ClearCyc - 1);
  localparam logic [CNT_W-1:0] PowerupLast = CNT_W'(PowerupCyc - 1);

  typedef enum logic [2:0] {
    StPowerup,
    StSetup,
    StPulse,
    StHold,
    StExec,
    StIdle
  } state_e;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    unique case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic [31:0] io_lcd;
  assign io_lcd = lcd_bus_io.io_lcd;

  logic unused_io_bits;
  assign unused_io_bits = ^{io_lcd[30:11], io_lcd[8]};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic             pend_q, pend_d;
  logic             pend_rs_q, pend_rs_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             start_q, start_d;
  logic             on_q, on_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;

  logic       start_edge;
  logic       is_clear;
  logic       exec_done;
  logic       load;
  logic       load_rs;
  logic [7:0] load_data;

  always_comb begin
    start_edge = io_lcd[10] & ~start_q;
    is_clear   = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02) | (data_q == 8'h03));
    exec_done  = is_clear ? (cnt_q == ClearLast) : (cnt_q == ExecLast);

    state_d     = state_q;
    init_idx_d  = init_idx_q;
    start_d     = io_lcd[10];
    on_d        = io_lcd[31];
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    load        = 1'b0;
    load_rs     = 1'b0;
    load_data   = 8'h00;

    if (start_edge) begin
      pend_d      = 1'b1;
      pend_rs_d   = io_lcd[9];
      pend_data_d = io_lcd[7:0];
    end

    unique case (state_q)
      StPowerup: begin
        if (cnt_q == PowerupLast) begin
          load       = 1'b1;
          load_data  = init_cmd(3'd0);
          init_idx_d = 3'd1;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StPulse;
          en_d    = 1'b1;
        end
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          state_d = StHold;
          en_d    = 1'b0;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) state_d = StExec;
      end
      StExec: begin
        if (exec_done) begin
          if (init_idx_q < 3'd4) begin
            load       = 1'b1;
            load_data  = init_cmd(init_idx_q);
            init_idx_d = init_idx_q + 3'd1;
          end else if (pend_q) begin
            load      = 1'b1;
            load_rs   = pend_rs_q;
            load_data = pend_data_q;
            // An edge landing on this very cycle becomes the next pending transfer.
            pend_d    = start_edge;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StIdle: begin
        if (start_edge) begin
          load      = 1'b1;
          load_rs   = io_lcd[9];
          load_data = io_lcd[7:0];
          pend_d    = 1'b0;
        end else if (pend_q) begin
          load      = 1'b1;
          load_rs   = pend_rs_q;
          load_data = pend_data_q;
          pend_d    = 1'b0;
        end
      end
      default: state_d = StPowerup;
    endcase

    if (load) begin
      state_d = StSetup;
      rs_d    = load_rs;
      data_d  = load_data;
    end

    if ((state_d != state_q) || (state_q == StIdle)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != StIdle) | pend_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPowerup;
      cnt_q       <= '0;
      init_idx_q  <= 3'd0;
      pend_q      <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      start_q     <= 1'b1;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      pend_q      <= pend_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      start_q     <= start_d;
      on_q        <= on_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign lcd_bus_io.lcd_on   = on_q;
  assign lcd_bus_io.lcd_en   = en_q;
  assign lcd_bus_io.lcd_rs   = rs_q;
  assign lcd_bus_io.lcd_rw   = 1'b0;
  assign lcd_bus_io.lcd_data = data_q;
  assign lcd_bus_io.busy     = busy_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Random START traffic against a transfer-level timeline model of lcd_ctrl, plus an
// asynchronous reset in mid-pulse and a START held high across reset.
module tb_lcd_ctrl;

  localparam int unsigned TS  = 2;
  localparam int unsigned TP  = 3;
  localparam int unsigned TH  = 2;
  localparam int unsigned TE  = 5;
  localparam int unsigned TC  = 10;
  localparam int unsigned TPU = 8;

  typedef struct {
    int unsigned cyc;
    logic        rs;
    logic [7:0]  data;
  } cap_t;

  typedef struct {
    int unsigned rise;
    logic        rs;
    logic [7:0]  data;
  } xfer_t;

  logic clk;
  logic rst_n;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_SETUP   (TS),
    .T_PULSE   (TP),
    .T_HOLD    (TH),
    .T_EXEC    (TE),
    .T_CLEAR   (TC),
    .T_POWERUP (TPU),
    .CNT_W     (20)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .lcd_bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number since reset release: edge k is the k-th posedge after release.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  cap_t        caps[$];
  xfer_t       exp_q[$];
  int unsigned idle_lo[$];
  int unsigned idle_hi[$];
  int          cidx;
  int unsigned drop_cyc;
  logic        on_drv;

  logic        prev_en;
  int unsigned rise_cyc, last_chg, last_fall;
  logic        rise_rs, last_rs;
  logic [7:0]  rise_data, last_data;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0:       return 8'h38;
      1:       return 8'h0C;
      2:       return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic int unsigned wait_of(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TC;
    return TE;
  endfunction

  function automatic cap_t rnd_cap(input int unsigned t);
    cap_t        c;
    int unsigned k;
    k = $urandom_range(0, 3);
    c.cyc = t;
    case (k)
      0:       begin c.rs = 1'b0; c.data = 8'($urandom_range(1, 3)); end
      1:       begin c.rs = 1'b0; c.data = 8'($urandom); end
      default: begin c.rs = 1'($urandom); c.data = 8'($urandom); end
    endcase
    return c;
  endfunction

  task automatic gen_caps(input int unsigned lo, input int unsigned hi, input int n);
    int unsigned t;
    caps.delete();
    t = $urandom_range(lo, hi);
    caps.push_back(rnd_cap(t));
    for (int i = 0; i < n; i++) begin
      t += $urandom_range(2, 30);
      caps.push_back(rnd_cap(t));
    end
  endtask

  // Timeline of transfers: each occupies setup+pulse+hold+wait edges; after init, the
  // newest capture seen before a transfer ends runs next, otherwise the block idles.
  task automatic build_model();
    int unsigned s, e;
    int          ii, ci;
    logic        rs;
    logic [7:0]  d;
    bit          found, done;
    xfer_t       x;
    exp_q.delete();
    idle_lo.delete();
    idle_hi.delete();
    s = TPU; rs = 1'b0; d = init_byte(0); ii = 1; ci = 0; done = 0;
    while (!done) begin
      x.rise = s + TS; x.rs = rs; x.data = d;
      exp_q.push_back(x);
      e = x.rise + TP + TH + wait_of(rs, d);
      if (ii < 4) begin
        rs = 1'b0; d = init_byte(ii); ii++; s = e;
      end else begin
        found = 0;
        while (ci < caps.size() && caps[ci].cyc < e) begin
          rs = caps[ci].rs; d = caps[ci].data; ci++; found = 1;
        end
        if (found) begin
          s = e;
        end else if (ci >= caps.size()) begin
          idle_lo.push_back(e);
          idle_hi.push_back(32'hFFFF_FFFF);
          done = 1;
        end else begin
          rs = caps[ci].rs; d = caps[ci].data;
          if (caps[ci].cyc == e) begin
            s = e + 1;
          end else begin
            idle_lo.push_back(e);
            idle_hi.push_back(caps[ci].cyc);
            s = caps[ci].cyc;
          end
          ci++;
        end
      end
    end
  endtask

  function automatic bit exp_busy(input int unsigned c);
    for (int i = 0; i < idle_lo.size(); i++) begin
      if (c >= idle_lo[i] && c < idle_hi[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic reset_monitor();
    prev_en = 1'b0; rise_cyc = 0; last_chg = 0; last_fall = 0;
    rise_rs = 1'b0; last_rs = 1'b0; rise_data = 8'h00; last_data = 8'h00;
    cidx = 0;
  endtask

  // One cycle: check outputs at the negedge, then drive the next io_lcd word.
  task automatic step();
    logic [31:0] io_v;
    xfer_t       x;
    @(negedge clk);
    check_eq("lcd_on", bus.lcd_on, on_drv);
    check_eq("lcd_rw", bus.lcd_rw, 0);
    check_eq("busy", bus.busy, exp_busy(cyc));
    if (bus.lcd_rs != last_rs || bus.lcd_data != last_data) begin
      check_eq("hold_time_ok", (cyc - last_fall) >= TH, 1);
      last_chg  = cyc;
      last_rs   = bus.lcd_rs;
      last_data = bus.lcd_data;
    end
    if (bus.lcd_en && !prev_en) begin
      check_eq("setup_time_ok", (cyc - last_chg) >= TS, 1);
      check_eq("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_eq("rise_edge", cyc, x.rise);
        check_eq("rise_rs", bus.lcd_rs, x.rs);
        check_eq("rise_data", bus.lcd_data, x.data);
      end
      rise_cyc = cyc; rise_rs = bus.lcd_rs; rise_data = bus.lcd_data;
    end
    if (!bus.lcd_en && prev_en) begin
      check_eq("pulse_width", cyc - rise_cyc, TP);
      check_eq("pulse_stable", {bus.lcd_rs, bus.lcd_data}, {rise_rs, rise_data});
      last_fall = cyc;
    end
    prev_en = bus.lcd_en;

    on_drv = 1'($urandom);
    io_v = $urandom;
    io_v[31] = on_drv;
    if (cidx < caps.size() && caps[cidx].cyc == cyc + 1) begin
      io_v[10]  = 1'b1;
      io_v[9]   = caps[cidx].rs;
      io_v[7:0] = caps[cidx].data;
      cidx++;
    end else begin
      io_v[10] = (cyc + 1 < drop_cyc);
    end
    bus.io_lcd = io_v;
  endtask

  task automatic run_until(input int unsigned end_cyc);
    int guard;
    guard = 0;
    while (cyc < end_cyc && guard < 5000) begin
      step();
      guard++;
    end
    check_eq("run_reached_end", cyc >= end_cyc, 1);
  endtask

  task automatic check_no_missing();
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].rise <= cyc) n++;
    check_eq("pulses_missing", n, 0);
  endtask

  initial begin
    int unsigned t;
    cap_t        c;
    xfer_t       x;

    // Phase 1: power-up init, then random START traffic.
    rst_n    = 1'b0;
    on_drv   = 1'($urandom);
    bus.io_lcd = {on_drv, 31'h0};
    drop_cyc = 0;
    gen_caps(3, 40, 40);
    build_model();
    reset_monitor();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_until(idle_lo[idle_lo.size() - 1] + 10);
    check_no_missing();

    // Launch one more transfer from idle and pull reset while E is high.
    t = cyc + 3;
    c = rnd_cap(t);
    caps.push_back(c);
    idle_hi[idle_hi.size() - 1] = t;
    x.rise = t + TS; x.rs = c.rs; x.data = c.data;
    exp_q.push_back(x);
    for (int k = 0; k < 10 && cyc != t + TS; k++) step();
    check_eq("en_high_before_reset", bus.lcd_en, 1);
    #2 rst_n = 1'b0;
    bus.io_lcd[10] = 1'b1;
    #1;
    check_eq("async_rst_en", bus.lcd_en, 0);
    check_eq("async_rst_busy", bus.busy, 1);
    check_eq("async_rst_on", bus.lcd_on, 0);
    check_eq("async_rst_rs_data", {bus.lcd_rs, bus.lcd_data}, 0);

    // Phase 2: START held high through reset must not fire until it toggles.
    drop_cyc = 20;
    gen_caps(22, 45, 12);
    build_model();
    reset_monitor();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    run_until(idle_lo[idle_lo.size() - 1] + 10);
    check_no_missing();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
